// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: carries IF predictions through ID/EX, checks them against the real outcome,
// drives the single BHT/BTB update and the mispredict redirect. Optional BR_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] PC_IF,
  input  logic            pred_taken_IF,
  input  logic [PC_W-1:0] pred_target_IF,
  input  logic            stall_ID,
  input  logic            stall_EX,
  input  logic            flush_ID,
  input  logic            flush_EX,
  input  logic            is_br_EX,
  input  logic            br_taken_EX,
  input  logic [PC_W-1:0] br_target_EX,
  output logic            bht_wr_req,
  output logic [PC_W-1:0] bht_PC,
  output logic            bht_taken,
  output logic            btb_wr_req,
  output logic            btb_valid,
  output logic [PC_W-1:0] btb_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_PC
`ifdef BR_STATS_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`endif
);

  typedef struct packed {
    logic            v;
    logic [PC_W-1:0] pc;
    logic            pt;
    logic [PC_W-1:0] tgt;
  } slot_t;

  slot_t id_q, id_d, ex_q, ex_d;
  logic  done_q, done_d;

  logic            res, tgt_mis;
  logic [PC_W-1:0] pc_inc, act_tgt;

  // Resolution outputs: everything is gated by a live, not-yet-resolved EX entry.
  always_comb begin
    res     = ex_q.v & ~done_q & ~rst;
    pc_inc  = ex_q.pc + PC_W'(4);
    act_tgt = br_taken_EX ? br_target_EX : pc_inc;
    tgt_mis = ex_q.tgt != br_target_EX;

    mispredict  = res & ((is_br_EX & ((ex_q.pt != br_taken_EX) | (ex_q.pt & br_taken_EX & tgt_mis)))
                       | (~is_br_EX & ex_q.pt));
    redirect_PC = res ? (is_br_EX ? act_tgt : pc_inc) : '0;

    bht_wr_req  = res & is_br_EX;
    bht_PC      = res ? ex_q.pc : '0;
    bht_taken   = res & br_taken_EX;

    // A non-branch that was predicted taken has a stale BTB entry: invalidate it.
    btb_wr_req  = res & ((is_br_EX & br_taken_EX & (~ex_q.pt | tgt_mis)) | (~is_br_EX & ex_q.pt));
    btb_valid   = res & is_br_EX;
    btb_target  = res ? br_target_EX : '0;
  end

  // Slot advance: squash > flush > stall > load.
  always_comb begin
    id_d   = id_q;
    ex_d   = ex_q;
    done_d = done_q;

    if (mispredict || flush_ID) id_d.v = 1'b0;
    else if (!stall_ID)         id_d   = '{v: 1'b1, pc: PC_IF, pt: pred_taken_IF, tgt: pred_target_IF};

    if (mispredict || flush_EX) begin
      ex_d.v = 1'b0;
      done_d = 1'b0;
    end else if (stall_EX) begin
      // Held entry already resolved this cycle; keep it from writing again.
      if (res) done_d = 1'b1;
    end else begin
      ex_d   = id_q;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q   <= '0;
      ex_q   <= '0;
      done_q <= 1'b0;
    end else begin
      id_q   <= id_d;
      ex_q   <= ex_d;
      done_q <= done_d;
    end
  end

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q + CNT_W'(bht_wr_req);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispredict);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes hand-computed responses, a negedge monitor pops/compares.
module tb_branch_resolve_unit;
  localparam int PC_W = 32;
  localparam logic [31:0] FILL = 32'h0000_0900;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] PC_IF, pred_target_IF, br_target_EX;
  logic            pred_taken_IF, stall_ID, stall_EX, flush_ID, flush_EX, is_br_EX, br_taken_EX;
  logic            bht_wr_req, bht_taken, btb_wr_req, btb_valid, mispredict;
  logic [PC_W-1:0] bht_PC, btb_target, redirect_PC;
`ifdef BR_STATS_EN
  logic [31:0]     br_cnt, mispred_cnt;
`endif

  branch_resolve_unit #(.PC_W(PC_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF), .pred_taken_IF(pred_taken_IF), .pred_target_IF(pred_target_IF),
    .stall_ID(stall_ID), .stall_EX(stall_EX), .flush_ID(flush_ID), .flush_EX(flush_EX),
    .is_br_EX(is_br_EX), .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
    .bht_wr_req(bht_wr_req), .bht_PC(bht_PC), .bht_taken(bht_taken),
    .btb_wr_req(btb_wr_req), .btb_valid(btb_valid), .btb_target(btb_target),
    .mispredict(mispredict), .redirect_PC(redirect_PC)
`ifdef BR_STATS_EN
    , .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mp;
    logic [31:0] redir;
    logic        bht;
    logic [31:0] pc;
    logic        tk;
    logic        btb;
    logic        bv;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Monitor: any strobe means the DUT presents a response.
  always @(negedge clk) begin
    if (bht_wr_req | btb_wr_req | mispredict) begin
      exp_t a, e;
      a = '{mp: mispredict, redir: redirect_PC, bht: bht_wr_req, pc: bht_PC, tk: bht_taken,
            btb: btb_wr_req, bv: btb_valid, tgt: btb_target};
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output t=%0t got mp=%b redir=%h bht=%b pc=%h tk=%b btb=%b bv=%b tgt=%h, want none",
                 $time, a.mp, a.redir, a.bht, a.pc, a.tk, a.btb, a.bv, a.tgt);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL resolve t=%0t got mp=%b redir=%h bht=%b pc=%h tk=%b btb=%b bv=%b tgt=%h",
                   $time, a.mp, a.redir, a.bht, a.pc, a.tk, a.btb, a.bv, a.tgt);
          $display("     want mp=%b redir=%h bht=%b pc=%h tk=%b btb=%b bv=%b tgt=%h",
                   e.mp, e.redir, e.bht, e.pc, e.tk, e.btb, e.bv, e.tgt);
        end
      end
    end
  end

  task automatic push(input logic mp, input logic [31:0] redir, input logic bht, input logic [31:0] pc,
                      input logic tk, input logic btb, input logic bv, input logic [31:0] tgt);
    q.push_back('{mp: mp, redir: redir, bht: bht, pc: pc, tk: tk, btb: btb, bv: bv, tgt: tgt});
  endtask

  task automatic drv(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                     input logic br, input logic tk, input logic [31:0] btgt);
    PC_IF = pc; pred_taken_IF = pt; pred_target_IF = ptgt;
    is_br_EX = br; br_taken_EX = tk; br_target_EX = btgt;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet(input string nm);
    #1;
    n_vec++;
    if ({bht_wr_req, btb_wr_req, mispredict} !== 3'b000) begin
      n_err++;
      $display("FAIL %s: strobes bht/btb/mp=%b, want 000", nm, {bht_wr_req, btb_wr_req, mispredict});
    end
  endtask

  task automatic all_zero(input string nm);
    n_vec++;
    if ({bht_wr_req, bht_PC, bht_taken, btb_wr_req, btb_valid, btb_target, mispredict, redirect_PC} !== '0) begin
      n_err++;
      $display("FAIL %s: outputs not all zero (mp=%b redir=%h bht=%b pc=%h btb=%b tgt=%h)",
               nm, mispredict, redirect_PC, bht_wr_req, bht_PC, btb_wr_req, btb_target);
    end
  endtask

  // Put a fetch into IF, then a filler behind it; returns with the fetch sitting in EX.
  task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    drv(pc, pt, ptgt, 1'b0, 1'b0, '0); tick();
    drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0); tick();
  endtask

  task automatic filler(input int n);
    for (int i = 0; i < n; i++) begin
      drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0); tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_ID = 1'b0; stall_EX = 1'b0; flush_ID = 1'b0; flush_EX = 1'b0;
    drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    all_zero("rst_init");
    rst = 1'b0;

    // Mid-stream async reset: a live mispredict must vanish without a clock edge.
    filler(2);
    issue(32'h700, 1'b0, '0);
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h780);
    #1;
    n_vec++;
    if (mispredict !== 1'b1) begin
      n_err++;
      $display("FAIL pre_rst_mp: mispredict=%b want 1", mispredict);
    end
    rst = 1'b1;
    #1;
    all_zero("rst_async");
    tick();
    rst = 1'b0;

    // After release the first fetch reaches EX only in the third cycle.
    drv(32'h100, 1'b0, '0, 1'b1, 1'b1, 32'h180); quiet("rst_lat_c1"); tick();
    drv(32'h100, 1'b0, '0, 1'b1, 1'b1, 32'h180); quiet("rst_lat_c2"); tick();
    drv(32'h100, 1'b0, '0, 1'b1, 1'b1, 32'h180);
    push(1'b1, 32'h180, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h180);
    tick();
    filler(3);

    // Clear stats before the counted tests.
    rst = 1'b1; tick(); rst = 1'b0;
    filler(2);

    // Correctly predicted taken branch: BHT refresh only.
    issue(32'h100, 1'b1, 32'h200);
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h200);
    push(1'b0, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    filler(2);

    // Predicted not-taken, actually taken: redirect and BTB install, then wrong path squashed.
    issue(32'h100, 1'b0, '0);
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h180);
    push(1'b1, 32'h180, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h180);
    tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h180); quiet("t3_squash_c1"); tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h180); quiet("t3_squash_c2"); tick();
    filler(2);

    // Predicted taken but not a branch: invalidate BTB, fall through.
    issue(32'h100, 1'b1, 32'h200);
    drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0);
    push(1'b1, 32'h104, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b0, '0); quiet("t4_squash"); tick();
    filler(2);

    // Branch held in EX for three cycles: one update only.
    issue(32'h400, 1'b1, 32'h480);
    stall_ID = 1'b1; stall_EX = 1'b1;
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h480);
    push(1'b0, 32'h480, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h480);
    tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h480); quiet("t5_hold_c2"); tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h480); quiet("t5_hold_c3"); tick();
    stall_ID = 1'b0; stall_EX = 1'b0;
    filler(3);

`ifdef BR_STATS_EN
    n_vec++;
    if (br_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL br_cnt: got %0d want 3", br_cnt);
    end
    n_vec++;
    if (mispred_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL mispred_cnt: got %0d want 2", mispred_cnt);
    end
`endif

    // Flush on the cycle the entry would enter EX: it never resolves.
    drv(32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0, '0); tick();
    flush_EX = 1'b1;
    drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0); tick();
    flush_EX = 1'b0;
    drv(FILL, 1'b0, '0, 1'b0, 1'b0, '0); quiet("t6_flushed"); tick();
    filler(2);

    // Top-of-address-space fall-through wraps to zero.
    issue(32'hFFFF_FFFC, 1'b1, 32'h40);
    drv(FILL, 1'b0, '0, 1'b1, 1'b0, 32'h40);
    push(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'h40);
    tick();
    drv(FILL, 1'b0, '0, 1'b1, 1'b1, 32'h40); quiet("t6_squash"); tick();
    filler(4);

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_output: no response seen, want mp=%b redir=%h bht=%b pc=%h btb=%b",
               e.mp, e.redir, e.bht, e.pc, e.btb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
